// File: rtl/ibuf_seq_ctrl.sv
// Input-buffer sequencer: fetches one wide word per tile, parallel-loads every
// column buffer, then issues diagonally skewed per-column shift enables.
module ibuf_seq_ctrl #(
  parameter int NCOL  = 4,
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 Start,
  input  logic                 Stop,
  input  logic [AW-1:0]        BaseAddr,
  input  logic [7:0]           NTile,
  output logic                 MemRE,
  output logic [AW-1:0]        MemAddr,
  input  logic [32*NCOL-1:0]   MemRData,
  output logic [NCOL-1:0]      WriteEN,
  output logic [32*NCOL-1:0]   IWord,
  output logic [NCOL-1:0]      ENDown,
  output logic                 Busy,
  output logic                 Done
);

  localparam int NSHIFT = NCOL + DEPTH - 1;
  localparam int KW     = $clog2(NSHIFT + 1);
  localparam logic [KW-1:0] KLAST = KW'(NSHIFT - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     base_q, base_d;
  logic [7:0]        ntile_q, ntile_d;
  logic [7:0]        t_q, t_d;
  logic [KW-1:0]     k_q, k_d;

  logic              memre_q;
  logic [AW-1:0]     memaddr_q;
  logic [NCOL-1:0]   wen_q;
  logic [NCOL-1:0]   endown_q;
  logic              busy_q;
  logic              done_q;

  // Column c is enabled for DEPTH beats starting at beat c: the diagonal wavefront.
  function automatic logic [NCOL-1:0] endown_f(input logic [KW-1:0] k);
    logic [NCOL-1:0] e;
    e = '0;
    for (int c = 0; c < NCOL; c++)
      e[c] = (int'(k) >= c) && (int'(k) <= c + DEPTH - 1);
    return e;
  endfunction

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    ntile_d = ntile_q;
    t_d     = t_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          base_d  = BaseAddr;
          ntile_d = NTile;
          t_d     = '0;
          state_d = (NTile == 8'd0) ? DONE : FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        k_d     = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (k_q == KLAST) begin
          t_d     = t_q + 8'd1;
          state_d = (({1'b0, t_q} + 9'd1) < {1'b0, ntile_q}) ? FETCH : DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort outranks every normal transition once a run is active.
    if (Stop && (state_q != IDLE))
      state_d = IDLE;
  end

  // Outputs are registered from the next state so they align with the state they describe.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= IDLE;
      base_q    <= '0;
      ntile_q   <= '0;
      t_q       <= '0;
      k_q       <= '0;
      memre_q   <= 1'b0;
      memaddr_q <= '0;
      wen_q     <= '0;
      endown_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      ntile_q   <= ntile_d;
      t_q       <= t_d;
      k_q       <= k_d;
      memre_q   <= (state_d == FETCH);
      memaddr_q <= (state_d == FETCH) ? (base_d + AW'(t_d)) : '0;
      wen_q     <= (state_d == LOAD) ? '1 : '0;
      endown_q  <= (state_d == SHIFT) ? endown_f(k_d) : '0;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
    end
  end

  assign MemRE   = memre_q;
  assign MemAddr = memaddr_q;
  assign WriteEN = wen_q;
  assign ENDown  = endown_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign IWord   = (state_q == LOAD) ? MemRData : '0;

endmodule

// File: tb/tb_ibuf_seq_ctrl.sv
// Directed bench for ibuf_seq_ctrl: per-cycle vector tables plus hand-written
// sequences for wrap, abort, start-while-busy and asynchronous reset.
module tb_ibuf_seq_ctrl;

  logic         CLK = 1'b0;
  logic         RSTN = 1'b0;
  logic         Start = 1'b0;
  logic         Stop = 1'b0;
  logic [7:0]   BaseAddr = '0;
  logic [7:0]   NTile = '0;
  logic         MemRE;
  logic [7:0]   MemAddr;
  logic [127:0] MemRData = '0;
  logic [3:0]   WriteEN;
  logic [127:0] IWord;
  logic [3:0]   ENDown;
  logic         Busy;
  logic         Done;

  always #5 CLK = ~CLK;

  ibuf_seq_ctrl #(.NCOL(4), .DEPTH(4), .AW(8)) dut (
    .CLK(CLK), .RSTN(RSTN), .Start(Start), .Stop(Stop),
    .BaseAddr(BaseAddr), .NTile(NTile),
    .MemRE(MemRE), .MemAddr(MemAddr), .MemRData(MemRData),
    .WriteEN(WriteEN), .IWord(IWord), .ENDown(ENDown),
    .Busy(Busy), .Done(Done)
  );

  logic [127:0] mem [256];
  always @(posedge CLK) if (MemRE) MemRData <= mem[MemAddr];

  typedef struct {
    logic start, stop;
    logic [7:0] base, ntile;
    logic memre;
    logic [7:0] addr;
    logic [3:0] wen, endn;
    logic busy, done;
    logic [127:0] iword;
  } vec_t;

  vec_t tbl[$];
  int nvec = 0;
  int nbad = 0;
  localparam logic [127:0] W10 = 128'hA1A2A3A4_B1B2B3B4_C1C2C3C4_D1D2D3D4;

  function automatic logic [146:0] obs();
    return {MemRE, MemAddr, WriteEN, ENDown, Busy, Done, IWord};
  endfunction

  task automatic chk(input string nm, input logic [146:0] act, input logic [146:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic sp, input logic [7:0] b,
                              input logic [7:0] n, input logic re, input logic [7:0] a,
                              input logic [3:0] w, input logic [3:0] e, input logic bs,
                              input logic dn, input logic [127:0] iw);
    vec_t v;
    v.start = st; v.stop = sp; v.base = b; v.ntile = n; v.memre = re; v.addr = a;
    v.wen = w; v.endn = e; v.busy = bs; v.done = dn; v.iword = iw;
    return v;
  endfunction

  task automatic run_tbl(input string nm);
    foreach (tbl[i]) begin
      @(negedge CLK);
      Start = tbl[i].start; Stop = tbl[i].stop;
      BaseAddr = tbl[i].base; NTile = tbl[i].ntile;
      chk($sformatf("%s c%0d", nm, i), obs(),
          {tbl[i].memre, tbl[i].addr, tbl[i].wen, tbl[i].endn,
           tbl[i].busy, tbl[i].done, tbl[i].iword});
    end
    Start = 1'b0; Stop = 1'b0;
  endtask

  task automatic fill_single();
    tbl.delete();
    tbl.push_back(mk(1, 0, 8'h10, 1, 0, 8'h00, 4'h0, 4'h0, 0, 0, '0));
    tbl.push_back(mk(0, 0, 8'h10, 1, 1, 8'h10, 4'h0, 4'h0, 1, 0, '0));
    tbl.push_back(mk(0, 0, 8'h10, 1, 0, 8'h00, 4'hF, 4'h0, 1, 0, W10));
    tbl.push_back(mk(0, 0, 8'h10, 1, 0, 8'h00, 4'h0, 4'h1, 1, 0, '0));
    tbl.push_back(mk(0, 0, 8'h10, 1, 0, 8'h00, 4'h0, 4'h3, 1, 0, '0));
    tbl.push_back(mk(0, 0, 8'h10, 1, 0, 8'h00, 4'h0, 4'h7, 1, 0, '0));
    tbl.push_back(mk(0, 0, 8'h10, 1, 0, 8'h00, 4'h0, 4'hF, 1, 0, '0));
    tbl.push_back(mk(0, 0, 8'h10, 1, 0, 8'h00, 4'h0, 4'hE, 1, 0, '0));
    tbl.push_back(mk(0, 0, 8'h10, 1, 0, 8'h00, 4'h0, 4'hC, 1, 0, '0));
    tbl.push_back(mk(0, 0, 8'h10, 1, 0, 8'h00, 4'h0, 4'h8, 1, 0, '0));
    tbl.push_back(mk(0, 0, 8'h10, 1, 0, 8'h00, 4'h0, 4'h0, 1, 1, '0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 0, 8'h10, 1, 0, 8'h00, 4'h0, 4'h0, 0, 0, '0));
  endtask

  task automatic wait_done(input int maxc, output int cyc);
    cyc = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge CLK);
      Start = 1'b0; Stop = 1'b0;
      if (Done) begin
        cyc = i;
        break;
      end
    end
  endtask

  int re_cyc[$];
  logic [7:0] re_addr[$];
  int overlaps, dones, dcyc;
  logic [7:0] last_addr;

  initial begin
    for (int i = 0; i < 256; i++)
      mem[i] = {4{8'(i), 8'(255 - i), 8'h5A, 8'(i ^ 8'h3C)}};
    mem[8'h10] = W10;
    mem[8'hFE] = 128'h11111111_22222222_33333333_44444444;
    mem[8'hFF] = 128'h55555555_66666666_77777777_88888888;
    mem[8'h00] = 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC;

    repeat (2) @(negedge CLK);
    chk("reset state", obs(), '0);
    RSTN = 1'b1;

    fill_single();
    run_tbl("single");

    // Start pulse with other parameters in the middle of the run must be ignored.
    fill_single();
    tbl[5].start = 1'b1;
    for (int i = 5; i < tbl.size(); i++) begin
      tbl[i].base = 8'h40; tbl[i].ntile = 8'd3;
    end
    run_tbl("busy_start");

    tbl.delete();
    tbl.push_back(mk(1, 0, 8'h10, 0, 0, 8'h00, 4'h0, 4'h0, 0, 0, '0));
    tbl.push_back(mk(0, 0, 8'h10, 0, 0, 8'h00, 4'h0, 4'h0, 1, 1, '0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 0, 8'h10, 0, 0, 8'h00, 4'h0, 4'h0, 0, 0, '0));
    run_tbl("zero");

    // Multi-tile with address wrap.
    @(negedge CLK);
    Start = 1'b1; BaseAddr = 8'hFE; NTile = 8'd3;
    overlaps = 0; dcyc = -1; last_addr = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge CLK);
      Start = 1'b0;
      if (MemRE) begin
        re_cyc.push_back(c); re_addr.push_back(MemAddr); last_addr = MemAddr;
      end
      if ((WriteEN & ENDown) != 4'h0) overlaps++;
      if (WriteEN == 4'hF)
        chk($sformatf("wrap iword c%0d", c), 147'(IWord), 147'(mem[last_addr]));
      if (Done) begin
        dcyc = c;
        break;
      end
    end
    chk("wrap memre count", 147'(re_cyc.size()), 147'(3));
    if (re_cyc.size() == 3) begin
      chk("wrap re cycles", 147'({re_cyc[0][7:0], re_cyc[1][7:0], re_cyc[2][7:0]}),
          147'({8'd1, 8'd10, 8'd19}));
      chk("wrap re addrs", 147'({re_addr[0], re_addr[1], re_addr[2]}),
          147'({8'hFE, 8'hFF, 8'h00}));
    end
    chk("wrap done cycle", 147'(dcyc), 147'(28));
    chk("wrap overlap", 147'(overlaps), 147'(0));
    @(negedge CLK);
    chk("wrap idle after", 147'(Busy), 147'(0));

    // Abort in the middle of the shift phase, then restart.
    @(negedge CLK);
    Start = 1'b1; BaseAddr = 8'h20; NTile = 8'd2;
    dones = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      Start = 1'b0; Stop = (c == 6);
      if (Done) dones++;
      if (c == 7) chk("stop c7", 147'({ENDown, Busy, Done}), 147'(0));
      if (c == 8) begin
        Start = 1'b1; BaseAddr = 8'h33; NTile = 8'd1;
      end
    end
    @(negedge CLK);
    Start = 1'b0;
    chk("restart memre", 147'({MemRE, MemAddr}), 147'({1'b1, 8'h33}));
    chk("stop no done", 147'(dones), 147'(0));
    wait_done(20, dcyc);
    chk("restart done", 147'(dcyc), 147'(9));

    // Stop together with Start in IDLE: the run starts.
    @(negedge CLK);
    Start = 1'b1; Stop = 1'b1; BaseAddr = 8'h05; NTile = 8'd1;
    @(negedge CLK);
    Start = 1'b0; Stop = 1'b0;
    chk("start+stop idle", 147'({MemRE, MemAddr, Busy}), 147'({1'b1, 8'h05, 1'b1}));
    wait_done(20, dcyc);
    chk("start+stop done", 147'(dcyc), 147'(9));

    // Asynchronous reset in the middle of a run.
    @(negedge CLK);
    Start = 1'b1; BaseAddr = 8'h50; NTile = 8'd2;
    for (int c = 1; c <= 5; c++) begin
      @(negedge CLK);
      Start = 1'b0;
    end
    #1 RSTN = 1'b0;
    #1 chk("async reset", obs(), '0);
    dones = 0;
    repeat (2) begin
      @(negedge CLK);
      if (Done) dones++;
    end
    RSTN = 1'b1;
    @(negedge CLK);
    if (Done) dones++;
    chk("post reset idle", obs(), '0);
    chk("reset no done", 147'(dones), 147'(0));
    Start = 1'b1; BaseAddr = 8'h60; NTile = 8'd1;
    @(negedge CLK);
    Start = 1'b0;
    chk("post reset memre", 147'({MemRE, MemAddr}), 147'({1'b1, 8'h60}));
    wait_done(20, dcyc);
    chk("post reset done", 147'(dcyc), 147'(9));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/ibuf_seq_ctrl.md
Name: ibuf_seq_ctrl

Overview:
- Sequencer for a row of input-buffer columns feeding the systolic MAC array.
- Per tile: fetches one wide word (one 32-bit word per column) from input memory, parallel-loads every column buffer, then issues skewed per-column ENDown pulses.
- Column c starts shifting one cycle after column c-1, which produces the diagonal data wavefront the array needs.
- Repeats for NTile consecutive addresses, then pulses Done.

Parameters:
- NCOL, 4, number of column buffers driven.
- DEPTH, 4, bytes per 32-bit word, i.e. shift beats per column per tile.
- AW, 8, memory address width.

Ports:
- CLK  in  1  clock.
- RSTN  in  1  reset, asynchronous, active-low.
- Start  in  1  begin a run; sampled only in IDLE.
- Stop  in  1  synchronous abort; honoured in any non-IDLE state.
- BaseAddr  in  AW  address of first tile word.
- NTile  in  8  number of tiles to stream.
- MemRE  out  1  memory read enable.
- MemAddr  out  AW  memory read address.
- MemRData  in  32*NCOL  read data, valid exactly 1 cycle after MemRE. Column c uses bits [32c+31:32c].
- WriteEN  out  NCOL  per-column parallel load.
- IWord  out  32*NCOL  per-column load word.
- ENDown  out  NCOL  per-column shift/propagate enable.
- Busy  out  1  run in progress.
- Done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, RSTN=0):
  - State=IDLE.
  - MemRE, MemAddr, WriteEN, IWord, ENDown, Busy and Done all read 0.
  - Counters cleared.
  - Reset mid-run abandons the run; no Done is produced.
- State machine: IDLE, FETCH, LOAD, SHIFT, DONE. All outputs are decoded from registered state/counters. IWord is the exception: it is a pass-through of MemRData while in LOAD.
- IDLE:
  - Start=1 latches BaseAddr and NTile, clears tile index t.
  - Next state is FETCH, or DONE when NTile==0.
  - Busy=0 only in IDLE.
- FETCH (1 cycle):
  - MemRE=1, MemAddr=(BaseAddr+t) mod 2^AW.
  - Next state: LOAD.
- LOAD (1 cycle):
  - WriteEN = all ones, IWord = MemRData.
  - Clear shift counter k.
  - Next state: SHIFT.
- SHIFT (NCOL+DEPTH-1 cycles; 7 at defaults):
  - k counts 0..NCOL+DEPTH-2.
  - ENDown[c]=1 iff c <= k <= c+DEPTH-1.
  - WriteEN is never asserted in SHIFT, so load and shift never overlap in a column.
  - On the last k: increment t. If t+1 < NTile go to FETCH, else go to DONE.
- DONE (1 cycle): Done=1, Busy=1. Next state: IDLE.
- Timing: tile period is 1+1+NCOL+DEPTH-1 = 9 cycles at defaults. With Start sampled at cycle 0, Done is at cycle 1+9*NTile.
- Stop=1 in FETCH/LOAD/SHIFT/DONE:
  - Next cycle is IDLE with all enables 0 and no Done pulse.
  - Stop outranks the normal transition.
  - Stop in IDLE is ignored.
  - Start and Stop together in IDLE: Stop ignored, run starts.
- Start while Busy=1 is ignored; latched parameters are unchanged.
- MemRData is ignored outside LOAD.
- Address wraps modulo 2^AW and the tile counter never wraps; NTile=255 is legal.

Test Plan:
- Single tile:
  - Stimulus: Start at cycle 0, BaseAddr=0x10, NTile=1, memory word at 0x10 = {0xA1A2A3A4, 0xB1B2B3B4, 0xC1C2C3C4, 0xD1D2D3D4}.
  - Response: MemRE=1 with MemAddr=0x10 at cycle 1; WriteEN=4'b1111 with IWord=that word at cycle 2.
  - ENDown[0] high cycles 3-6, ENDown[1] high 4-7, ENDown[2] high 5-8, ENDown[3] high 6-9.
  - Done at cycle 10; Busy high cycles 1-10.
- Multi-tile wrap:
  - Stimulus: BaseAddr=0xFE, NTile=3.
  - Response: MemRE at cycles 1, 10, 19 with addresses 0xFE, 0xFF, 0x00; Done at cycle 28; no WriteEN/ENDown overlap in any column.
- Zero tiles:
  - Stimulus: NTile=0.
  - Response: Done at cycle 1, Busy high only at cycle 1; MemRE, WriteEN and ENDown never asserted.
- Stop mid-shift:
  - Stimulus: NTile=2, Stop at cycle 6.
  - Response: cycle 7 has ENDown=0, Busy=0, and no Done ever.
  - Follow-on Start at cycle 8 produces MemRE at cycle 9 with the new BaseAddr.
- Start while busy:
  - Stimulus: pulse Start with different BaseAddr/NTile at cycle 5 of a 1-tile run.
  - Response: run unaffected, Done at cycle 10, no second run.
- Async reset:
  - Stimulus: RSTN low at cycle 5 (mid-SHIFT).
  - Response: all outputs 0 immediately; after release, state is IDLE and a new Start runs normally.
